// File: rtl/phaethon_mem_ctrl_pkg.sv
// Shared constants for the Phaethon memory controller.
// These are the state encodings, the debug-word layout and the page-table defaults.
package phaethon_mc_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned CNT_W   = 16;

   localparam logic [ADDR_W-1:0] PT_BASE_DEFAULT   = 32'h0000_1000;
   localparam int unsigned       PAGE_BITS_DEFAULT = 12;

   // The encodings follow the order of the debug field, starting at 0.
   localparam logic [STATE_W-1:0] ST_IDLE       = 4'd0;
   localparam logic [STATE_W-1:0] ST_RD_ISSUE   = 4'd1;
   localparam logic [STATE_W-1:0] ST_RD_CAPTURE = 4'd2;
   localparam logic [STATE_W-1:0] ST_WR_ISSUE   = 4'd3;
   localparam logic [STATE_W-1:0] ST_ACK        = 4'd4;
   localparam logic [STATE_W-1:0] ST_WAIT_REL   = 4'd5;
   localparam logic [STATE_W-1:0] ST_PT_ISSUE   = 4'd6;
   localparam logic [STATE_W-1:0] ST_PT_CAPTURE = 4'd7;

   localparam int unsigned DBG_STATE_LSB = 0;
   localparam int unsigned DBG_STATE_MSB = 3;
   localparam int unsigned DBG_CNT_LSB   = 16;
   localparam int unsigned DBG_CNT_MSB   = 31;

   // The debug word is laid out as {transaction count, zeros, state}.
   function automatic logic [DATA_W-1:0] packDebug(input logic [STATE_W-1:0] st,
                                                   input logic [CNT_W-1:0]   cnt);
      logic [DATA_W-1:0] dbg;
      dbg = '0;
      dbg[DBG_STATE_MSB:DBG_STATE_LSB] = st;
      dbg[DBG_CNT_MSB:DBG_CNT_LSB]     = cnt;
      return dbg;
   endfunction

endpackage

// File: rtl/phaethon_mem_ctrl_if.sv
// Client (mc) and physical RAM (ph) signal bundle for phaethon_mem_ctrl.
// The slave modport is the controller's view, and the master modport is the CPU/RAM side.
interface phaethon_mem_ctrl_if;
   import phaethon_mc_pkg::*;

   logic [DATA_W-1:0] mcRamRead;
   logic              mcRamReady;
   logic [ADDR_W-1:0] mcRamAddress;
   logic [DATA_W-1:0] mcRamWrite;
   logic              mcReadReq;
   logic              mcWriteReq;
   logic              mcAddrVirtual;
   logic [DATA_W-1:0] phRamRead;
   logic [ADDR_W-1:0] phRamAddress;
   logic [DATA_W-1:0] phRamWrite;
   logic              phReadReq;
   logic              phWriteReq;
   logic [DATA_W-1:0] mcDebug;

   modport slave (
      output mcRamRead, mcRamReady, phRamAddress, phRamWrite, phReadReq, phWriteReq, mcDebug,
      input  mcRamAddress, mcRamWrite, mcReadReq, mcWriteReq, mcAddrVirtual, phRamRead
   );

   modport master (
      input  mcRamRead, mcRamReady, phRamAddress, phRamWrite, phReadReq, phWriteReq, mcDebug,
      output mcRamAddress, mcRamWrite, mcReadReq, mcWriteReq, mcAddrVirtual, phRamRead
   );

endinterface

// File: rtl/phaethon_mem_ctrl.sv
// Single-port memory controller that turns held client requests into one-cycle RAM strobes.
// Optional virtual-address translation through an in-memory page table: PHAETHON_MC_VIRT_ADDR_EN.
module phaethon_mem_ctrl
   import phaethon_mc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PT_BASE   = PT_BASE_DEFAULT,
   parameter int unsigned       PAGE_BITS = PAGE_BITS_DEFAULT
) (
   input logic                clk,
   input logic                reset,
   phaethon_mem_ctrl_if.slave bus
);

   logic [STATE_W-1:0] stateQ, stateD;
   logic [DATA_W-1:0]  readDataQ, readDataD;
   logic               readyQ, readyD;
   logic [ADDR_W-1:0]  phAddrQ, phAddrD;
   logic [DATA_W-1:0]  phWdataQ, phWdataD;
   logic               phRdQ, phRdD;
   logic               phWrQ, phWrD;
   logic [CNT_W-1:0]   cntQ, cntD;
   logic [DATA_W-1:0]  debugQ;
   logic               reqAny;

   assign reqAny = bus.mcReadReq | bus.mcWriteReq;

`ifdef PHAETHON_MC_VIRT_ADDR_EN
   logic [PAGE_BITS-1:0] vOffsetQ, vOffsetD;
   logic                 pendWriteQ, pendWriteD;
   logic [ADDR_W-1:0]    ptEntryAddr;

   // Each page-table entry is one 32-bit word, indexed by the virtual page number.
   assign ptEntryAddr = PT_BASE + (ADDR_W'(bus.mcRamAddress >> PAGE_BITS) << 2);
`else
   logic unusedVirt;
   localparam logic [ADDR_W-1:0] unusedCfg = PT_BASE + ADDR_W'(PAGE_BITS);
   assign unusedVirt = bus.mcAddrVirtual ^ unusedCfg[0];
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ    <= ST_IDLE;
         readDataQ <= '0;
         readyQ    <= 1'b0;
         phAddrQ   <= '0;
         phWdataQ  <= '0;
         phRdQ     <= 1'b0;
         phWrQ     <= 1'b0;
         cntQ      <= '0;
         debugQ    <= '0;
`ifdef PHAETHON_MC_VIRT_ADDR_EN
         vOffsetQ   <= '0;
         pendWriteQ <= 1'b0;
`endif
      end else begin
         stateQ    <= stateD;
         readDataQ <= readDataD;
         readyQ    <= readyD;
         phAddrQ   <= phAddrD;
         phWdataQ  <= phWdataD;
         phRdQ     <= phRdD;
         phWrQ     <= phWrD;
         cntQ      <= cntD;
         debugQ    <= packDebug(stateD, cntD);
`ifdef PHAETHON_MC_VIRT_ADDR_EN
         vOffsetQ   <= vOffsetD;
         pendWriteQ <= pendWriteD;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      stateD    = stateQ;
      readDataD = readDataQ;
      readyD    = 1'b0;
      phAddrD   = phAddrQ;
      phWdataD  = phWdataQ;
      phRdD     = 1'b0;
      phWrD     = 1'b0;
      cntD      = cntQ;
`ifdef PHAETHON_MC_VIRT_ADDR_EN
      vOffsetD   = vOffsetQ;
      pendWriteD = pendWriteQ;
`endif

      case (stateQ)
         ST_IDLE: begin
            if (reqAny) begin
               phAddrD = bus.mcRamAddress;
`ifdef PHAETHON_MC_VIRT_ADDR_EN
               if (bus.mcAddrVirtual) begin
                  // Fetch the page-table entry first and remember what to do afterwards.
                  phAddrD    = ptEntryAddr;
                  vOffsetD   = bus.mcRamAddress[PAGE_BITS-1:0];
                  pendWriteD = ~bus.mcReadReq;
                  if (!bus.mcReadReq) begin
                     phWdataD = bus.mcRamWrite;
                  end
                  phRdD  = 1'b1;
                  stateD = ST_PT_ISSUE;
               end else
`endif
               if (bus.mcReadReq) begin
                  phRdD  = 1'b1;
                  stateD = ST_RD_ISSUE;
               end else begin
                  phWdataD = bus.mcRamWrite;
                  phWrD    = 1'b1;
                  stateD   = ST_WR_ISSUE;
               end
            end
         end

         ST_RD_ISSUE: stateD = ST_RD_CAPTURE;

         ST_RD_CAPTURE: begin
            readDataD = bus.phRamRead;
            readyD    = 1'b1;
            cntD      = cntQ + CNT_W'(1);
            stateD    = ST_ACK;
         end

         ST_WR_ISSUE: begin
            readyD = 1'b1;
            cntD   = cntQ + CNT_W'(1);
            stateD = ST_ACK;
         end

         ST_ACK: stateD = reqAny ? ST_WAIT_REL : ST_IDLE;

         // A request that is still held here has already been served and must not be issued again.
         ST_WAIT_REL: begin
            if (!reqAny) begin
               stateD = ST_IDLE;
            end
         end

`ifdef PHAETHON_MC_VIRT_ADDR_EN
         ST_PT_ISSUE: stateD = ST_PT_CAPTURE;

         ST_PT_CAPTURE: begin
            phAddrD = {bus.phRamRead[ADDR_W-1:PAGE_BITS], vOffsetQ};
            if (pendWriteQ) begin
               phWrD  = 1'b1;
               stateD = ST_WR_ISSUE;
            end else begin
               phRdD  = 1'b1;
               stateD = ST_RD_ISSUE;
            end
         end
`endif

         default: stateD = ST_IDLE;
      endcase
   end

   assign bus.mcRamRead    = readDataQ;
   assign bus.mcRamReady   = readyQ;
   assign bus.phRamAddress = phAddrQ;
   assign bus.phRamWrite   = phWdataQ;
   assign bus.phReadReq    = phRdQ;
   assign bus.phWriteReq   = phWrQ;
   assign bus.mcDebug      = debugQ;

endmodule

// File: tb/tb_phaethon_mem_ctrl.sv
// Self-checking bench for phaethon_mem_ctrl, with a byte-wide RAM model and a read-data scoreboard.
// Build with PHAETHON_MC_VIRT_ADDR_EN defined to exercise address translation.
module tb_phaethon_mem_ctrl;
   import phaethon_mc_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   phaethon_mem_ctrl_if bus();

   phaethon_mem_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Little-endian RAM: read data is valid the cycle after the strobe.
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (bus.phReadReq) begin
         bus.phRamRead <= {mem[16'(bus.phRamAddress[15:0] + 16'd3)],
                           mem[16'(bus.phRamAddress[15:0] + 16'd2)],
                           mem[16'(bus.phRamAddress[15:0] + 16'd1)],
                           mem[bus.phRamAddress[15:0]]};
      end
      if (bus.phWriteReq) begin
         mem[bus.phRamAddress[15:0]]                 <= bus.phRamWrite[7:0];
         mem[16'(bus.phRamAddress[15:0] + 16'd1)]    <= bus.phRamWrite[15:8];
         mem[16'(bus.phRamAddress[15:0] + 16'd2)]    <= bus.phRamWrite[23:16];
         mem[16'(bus.phRamAddress[15:0] + 16'd3)]    <= bus.phRamWrite[31:24];
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        isRead;
      logic [31:0] data;
   } sb_t;
   sb_t sb[$];

   int rdStrobes = 0, wrStrobes = 0, readyPulses = 0, overlap = 0, longStrobe = 0;
   logic [31:0] strobeLog[$];
   logic prevRd = 1'b0, prevWr = 1'b0;

   // Bus monitor: strobe bookkeeping and the scoreboard pop on every ready pulse.
   always @(negedge clk) begin
      if (bus.phReadReq)  rdStrobes++;
      if (bus.phWriteReq) wrStrobes++;
      if (bus.phReadReq || bus.phWriteReq) strobeLog.push_back(bus.phRamAddress);
      if (bus.phReadReq && bus.phWriteReq) overlap++;
      if ((bus.phReadReq && prevRd) || (bus.phWriteReq && prevWr)) longStrobe++;
      prevRd = bus.phReadReq;
      prevWr = bus.phWriteReq;
      if (bus.mcRamReady) begin
         readyPulses++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_ready actual=ready required=no_ready");
         end else begin
            sb_t e;
            e = sb.pop_front();
            if (e.isRead) chk("sb_rdata", bus.mcRamRead, e.data);
         end
      end
   end

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic        virt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      int          expLat;
      logic [31:0] expFirstAddr;
      logic [31:0] expLastAddr;
      int          expRd;
      int          expWr;
   } vec_t;

   int txCount = 0;

   task automatic idleReqs();
      bus.mcReadReq     = 1'b0;
      bus.mcWriteReq    = 1'b0;
      bus.mcAddrVirtual = 1'b0;
   endtask

   // One complete transaction. Cycle 0 is the cycle in which the request is sampled.
   task automatic runTxn(input vec_t v);
      int lat, rd0, wr0, rdy0, log0;
      lat  = -1;
      @(negedge clk);
      rd0 = rdStrobes; wr0 = wrStrobes; rdy0 = readyPulses; log0 = strobeLog.size();
      bus.mcRamAddress  = v.addr;
      bus.mcRamWrite    = v.wdata;
      bus.mcReadReq     = v.rd;
      bus.mcWriteReq    = v.wr;
      bus.mcAddrVirtual = v.virt;
      sb.push_back('{isRead: v.rd, data: v.expData});
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.mcRamReady) begin
            lat = k;
            break;
         end
      end
      idleReqs();
      repeat (2) @(negedge clk);
      txCount++;
      chk({v.name, "_latency"}, 32'(lat), 32'(v.expLat));
      chk({v.name, "_rd_strobes"}, 32'(rdStrobes - rd0), 32'(v.expRd));
      chk({v.name, "_wr_strobes"}, 32'(wrStrobes - wr0), 32'(v.expWr));
      chk({v.name, "_ready_pulses"}, 32'(readyPulses - rdy0), 32'd1);
      if (strobeLog.size() > log0) begin
         chk({v.name, "_first_addr"}, strobeLog[log0], v.expFirstAddr);
         chk({v.name, "_last_addr"}, strobeLog[strobeLog.size() - 1], v.expLastAddr);
      end else begin
         checks++;
         failures++;
         $display("FAIL %s_no_strobe actual=0 required=strobe", v.name);
      end
      chk({v.name, "_debug"}, bus.mcDebug, {16'(txCount), 16'h0000});
   endtask

   function automatic vec_t mk(input string n, input logic rd, input logic wr, input logic virt,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ed,
                               input int lat, input logic [31:0] fa, input logic [31:0] la,
                               input int nr, input int nw);
      vec_t v;
      v.name = n; v.rd = rd; v.wr = wr; v.virt = virt; v.addr = a; v.wdata = wd;
      v.expData = ed; v.expLat = lat; v.expFirstAddr = fa; v.expLastAddr = la;
      v.expRd = nr; v.expWr = nw;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      int rdy0, rd0;
      #200000;
      $display("FAIL global_timeout actual=hung required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rdy0, rd0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0010] = 8'h78; mem[16'h0011] = 8'h56; mem[16'h0012] = 8'h34; mem[16'h0013] = 8'h12;
      mem[16'h0030] = 8'h01; mem[16'h0031] = 8'h00; mem[16'h0032] = 8'hA5; mem[16'h0033] = 8'hA5;
      mem[16'h1004] = 8'h00; mem[16'h1005] = 8'h50; mem[16'h1006] = 8'h00; mem[16'h1007] = 8'h00;
      mem[16'h5234] = 8'h44; mem[16'h5235] = 8'h33; mem[16'h5236] = 8'h22; mem[16'h5237] = 8'h11;

      vecs.push_back(mk("rd10",   1, 0, 0, 32'h10, 32'h0,          32'h12345678, 3, 32'h10, 32'h10, 1, 0));
      vecs.push_back(mk("wr20",   0, 1, 0, 32'h20, 32'hDEADBEEF,   32'h0,        2, 32'h20, 32'h20, 0, 1));
      vecs.push_back(mk("rd20",   1, 0, 0, 32'h20, 32'h0,          32'hDEADBEEF, 3, 32'h20, 32'h20, 1, 0));
      vecs.push_back(mk("both30", 1, 1, 0, 32'h30, 32'hCAFEF00D,   32'hA5A50001, 3, 32'h30, 32'h30, 1, 0));
      vecs.push_back(mk("wr40",   0, 1, 0, 32'h40, 32'h01020304,   32'h0,        2, 32'h40, 32'h40, 0, 1));
      vecs.push_back(mk("rd40",   1, 0, 0, 32'h40, 32'h0,          32'h01020304, 3, 32'h40, 32'h40, 1, 0));
`ifdef PHAETHON_MC_VIRT_ADDR_EN
      vecs.push_back(mk("vrd1234", 1, 0, 1, 32'h1234, 32'h0,       32'h11223344, 5, 32'h1004, 32'h5234, 2, 0));
`else
      vecs.push_back(mk("vrd10",  1, 0, 1, 32'h10, 32'h0,          32'h12345678, 3, 32'h10, 32'h10, 1, 0));
`endif

      idleReqs();
      bus.mcRamAddress = '0;
      bus.mcRamWrite   = '0;

      // Reset held low
      repeat (3) @(negedge clk);
      chk("rst_mcRamRead", bus.mcRamRead, 32'h0);
      chk("rst_mcRamReady", 32'(bus.mcRamReady), 32'h0);
      chk("rst_phRamAddress", bus.phRamAddress, 32'h0);
      chk("rst_phRamWrite", bus.phRamWrite, 32'h0);
      chk("rst_phReadReq", 32'(bus.phReadReq), 32'h0);
      chk("rst_phWriteReq", 32'(bus.phWriteReq), 32'h0);
      chk("rst_mcDebug", bus.mcDebug, 32'h0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         runTxn(vecs[i]);
         if (vecs[i].name == "wr20") begin
            chk("mem20_b0", 32'(mem[16'h20]), 32'hEF);
            chk("mem20_b1", 32'(mem[16'h21]), 32'hBE);
            chk("mem20_b2", 32'(mem[16'h22]), 32'hAD);
            chk("mem20_b3", 32'(mem[16'h23]), 32'hDE);
         end
      end

      // Read held for 10 cycles: served once, then parked in WAIT_REL
      @(negedge clk);
      rdy0 = readyPulses; rd0 = rdStrobes;
      bus.mcRamAddress = 32'h10;
      bus.mcReadReq    = 1'b1;
      sb.push_back('{isRead: 1'b1, data: 32'h12345678});
      repeat (10) @(negedge clk);
      chk("hold_rd_strobes", 32'(rdStrobes - rd0), 32'd1);
      chk("hold_ready_pulses", 32'(readyPulses - rdy0), 32'd1);
      chk("hold_state", 32'(bus.mcDebug[3:0]), 32'(ST_WAIT_REL));
      txCount++;
      chk("hold_count", 32'(bus.mcDebug[31:16]), 32'(txCount));
      idleReqs();
      repeat (2) @(negedge clk);
      chk("hold_release_state", 32'(bus.mcDebug[3:0]), 32'(ST_IDLE));
      runTxn(mk("after_hold", 1, 0, 0, 32'h20, 32'h0, 32'hDEADBEEF, 3, 32'h20, 32'h20, 1, 0));

      // Reset asserted while the read strobe is high
      @(negedge clk);
      rdy0 = readyPulses;
      bus.mcRamAddress = 32'h40;
      bus.mcReadReq    = 1'b1;
      @(negedge clk);
      chk("abort_strobe_before", 32'(bus.phReadReq), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("abort_strobe_dropped", 32'(bus.phReadReq), 32'h0);
      chk("abort_debug", bus.mcDebug, 32'h0);
      idleReqs();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_no_ready", 32'(readyPulses - rdy0), 32'd0);
      txCount = 0;
      runTxn(mk("after_abort", 1, 0, 0, 32'h40, 32'h0, 32'h01020304, 3, 32'h40, 32'h40, 1, 0));

      chk("strobe_overlap", 32'(overlap), 32'd0);
      chk("strobe_long", 32'(longStrobe), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phaethon_mem_ctrl.md
Name: phaethon_mem_ctrl

Overview:
- Single-port memory controller between the Phaethon CPU core (client side, "mc" signals) and a byte-addressed physical RAM (physical side, "ph" signals).
- Converts level-held client read/write requests into one-cycle physical strobes and returns a one-cycle ready pulse.
- Optionally translates virtual addresses through an in-memory page table.

Parameters:
- PT_BASE, 32'h0000_1000, physical byte address of the page table; used only with VIRT_ADDR_EN.
- PAGE_BITS, 12, page offset width; used only with VIRT_ADDR_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- mcRamRead  out  32  read data returned to the client; holds the last read value
- mcRamReady  out  1  one-cycle pulse: the transaction is complete
- mcRamAddress  in  32  client byte address
- mcRamWrite  in  32  client write data
- mcReadReq  in  1  client read request, held high until ready
- mcWriteReq  in  1  client write request, held high until ready
- mcAddrVirtual  in  1  the client address is virtual
- phRamRead  in  32  physical RAM data, little-endian, valid the cycle after phReadReq
- phRamAddress  out  32  physical byte address
- phRamWrite  out  32  physical write data
- phReadReq  out  1  physical read strobe, one cycle
- phWriteReq  out  1  physical write strobe, one cycle
- mcDebug  out  32  debug status

Behaviour:
- All outputs are registered.
- Reset (reset low, asynchronous): all outputs are 0 and the state is IDLE.
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, ACK, WAIT_REL. PT_ISSUE and PT_CAPTURE exist only with VIRT_ADDR_EN.
- IDLE:
  - On mcReadReq=1, register phRamAddress = mcRamAddress, set phReadReq=1, go to RD_ISSUE.
  - On mcWriteReq=1, also register phRamWrite = mcRamWrite, set phWriteReq=1, go to WR_ISSUE.
  - If both requests are high, the read wins and the write is ignored.
- RD_ISSUE: drop phReadReq; go to RD_CAPTURE.
- RD_CAPTURE: mcRamRead <= phRamRead, set mcRamReady=1, go to ACK.
- WR_ISSUE: drop phWriteReq, set mcRamReady=1, go to ACK.
- ACK: clear mcRamReady. Go to WAIT_REL if a request is still high, otherwise go to IDLE.
- WAIT_REL: stay until mcReadReq=0 and mcWriteReq=0, then go to IDLE. This prevents a held request from being re-issued.
- Latency, with the request sampled in cycle 0:
  - Read: phReadReq high in cycle 1; mcRamReady and the data valid in cycle 3.
  - Write: phWriteReq high in cycle 1; mcRamReady high in cycle 2.
- Physical strobes are never high for more than one cycle, and phReadReq and phWriteReq are never high together.
- Request changes outside IDLE are ignored; the latched address and data are used.
- Reset mid-transaction aborts it: strobes drop immediately, no ready pulse.
- mcDebug:
  - [3:0] state encoding, in listed order from 0.
  - [15:4] zero.
  - [31:16] count of completed transactions, wrapping at 16 bits.

Optional Feature:
- Macro: PHAETHON_MC_VIRT_ADDR_EN.
- Defined, when IDLE accepts a request with mcAddrVirtual=1:
  - First read the page-table entry at PT_BASE + 4*(mcRamAddress >> PAGE_BITS), via PT_ISSUE/PT_CAPTURE (same timing as a read).
  - Then form the physical address: entry[31:PAGE_BITS] concatenated with the low PAGE_BITS bits of mcRamAddress.
  - Then continue as a normal read or write. This adds 2 cycles.
  - Requests with mcAddrVirtual=0 are unchanged.
- Undefined: mcAddrVirtual is ignored, all addresses are physical, and the PT states do not exist.

Decomposition:
- Package phaethon_mc_pkg holds:
  - the state enum (explicit 4-bit encoding);
  - the debug-field bit positions;
  - the default PT_BASE and PAGE_BITS constants.
- No sub-module; a single FSM module.

Test Plan:
- Reset held low → all outputs 0 and mcDebug[3:0]=0. Asserting reset mid-read → phReadReq drops immediately and no ready pulse follows.
- RAM bytes at 0x10..0x13 = 78,56,34,12; read of 0x10 → phReadReq one cycle, then mcRamReady in cycle 3 with mcRamRead=0x12345678.
- Write 0xDEADBEEF to 0x20 → phWriteReq one cycle with phRamAddress=0x20; mcRamReady in cycle 2; RAM bytes EF,BE,AD,DE; read-back returns 0xDEADBEEF.
- Read request held high for 10 cycles → exactly one phReadReq and one ready pulse, state stays in WAIT_REL. After release a new read is accepted; mcDebug[31:16] increments per transaction.
- mcReadReq and mcWriteReq both high → a read is performed and no phWriteReq occurs.
- With PHAETHON_MC_VIRT_ADDR_EN, PT entry at 0x1004 = 0x0000_5000: virtual read of 0x1234 → the PT read hits 0x1004, then the data read hits 0x5234; ready in cycle 5.
